alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Execute-stage consumer of the 3-bit ALUControl code produced by the decode-side ALU decoder. Performs the operation on two XLEN operands and registers the result with a valid/ready elastic handshake. Includes a one-entry skid buffer so downstream backpressure never loses an accepted operation.
- Sits between the ID/EX operand latch and the EX/MEM boundary. Also supplies the Zero flag used for beq resolution.

Parameters:
- XLEN, 32, operand/result width in bits (>= 8)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream offers an operation this cycle
- in_ready  output  1  stage can accept; transfer occurs when in_valid && in_ready
- alu_control  input  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 111 nop; 100/110 reserved
- src_a  input  XLEN  operand A
- src_b  input  XLEN  operand B
- rd_in  input  5  destination register tag, passed through
- flush  input  1  synchronous kill of all held/in-flight operations
- out_valid  output  1  result register holds a valid operation
- out_ready  input  1  downstream accepts; transfer occurs when out_valid && out_ready
- result  output  XLEN  registered ALU result
- zero  output  1  registered (result == 0)
- rd_out  output  5  registered destination tag
- illegal_op  output  1  registered; set when the code was 100 or 110

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, result=0, zero=0, rd_out=0, illegal_op=0, skid entry empty, in_ready=1 once reset is released.
- Arithmetic:
  - add/sub wrap modulo 2^XLEN; no carry or overflow output.
  - and/or are bitwise.
  - slt is a signed compare: result = {XLEN-1 zeros, (signed src_a < signed src_b)}.
  - nop (111) yields result=0, zero=1, illegal_op=0.
  - Reserved codes yield result=0, zero=1, illegal_op=1. The operation still flows as valid.
- Storage: output register (R) plus one skid entry (S). The skid entry holds the same fields as the outputs.
- in_ready = !S.valid. This is a registered-state function with no combinational path from out_ready.
- Latency: 1 cycle. An operation accepted at edge N appears on the outputs after edge N when R is free or draining.
- Per rising edge, without flush, in priority order:
  - R drains (out_ready && out_valid) and S is valid: R <= S, S <= empty. A new accept is impossible here because in_ready=0.
  - R drains (or R is empty) and an accept occurs: R <= new op.
  - R holds (out_valid && !out_ready) and an accept occurs: S <= new op. in_ready drops the next cycle.
  - R drains and there is no accept and S is empty: out_valid <= 0. Data fields keep their last value.
- Ordering is strict FIFO. No operation is duplicated or dropped except by flush.
- While out_valid=1 and out_ready=0, result, zero, rd_out and illegal_op stay stable.
- Flush at an edge:
  - R.valid <= 0 and S.valid <= 0.
  - Any simultaneous in_valid&&in_ready transfer is discarded.
  - A simultaneous downstream handshake counts as completed.
  - in_ready=1 on the following cycle.
- Reset mid-operation discards all contents immediately, independent of clk.

Test Plan:
- Back-to-back, out_ready=1: add 5+7, sub 5-5, and F0&3C, or F0|0F, each with in_valid=1 on consecutive cycles -> results 12, 0 (zero=1), 0x30, 0xFF appear one cycle after each accept, in order, with out_valid continuous.
- Signed slt: src_a=0xFFFFFFFF, src_b=1 -> result=1; then src_a=1, src_b=0xFFFFFFFF -> result=0.
- Backpressure: hold out_ready=0 and send 3 ops (tags rd 1, 2, 3) -> accepts rd1 and rd2, then in_ready=0 with rd3 stalled upstream. Release out_ready -> outputs rd1, rd2, rd3 in order, and the result stays stable while stalled.
- Flush with R and S both full plus in_valid=1 at the same edge -> next cycle out_valid=0, in_ready=1, and none of the three ops ever appear.
- Reserved code 110 with src_a=9, src_b=3 -> result=0, zero=1, illegal_op=1, out_valid=1. Code 111 -> illegal_op=0, result=0.
- Assert rst_n low asynchronously between clock edges with R and S full -> out_valid=0, result=0, and in_ready=1 immediately after release.

Source files
------------

// File: rtl/alu_exec_stage_if.sv
// Handshake/operand bundle between the ID/EX operand latch, the ALU
// execute stage and the EX/MEM boundary.
interface alu_exec_stage_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      alu_control;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [4:0]      rd_in;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [4:0]      rd_out;
  logic            illegal_op;

  // The execute stage itself.
  modport slave (
    input  in_valid, alu_control, src_a, src_b, rd_in, flush, out_ready,
    output in_ready, out_valid, result, zero, rd_out, illegal_op
  );

  // Whoever drives operations in and takes results out.
  modport master (
    output in_valid, alu_control, src_a, src_b, rd_in, flush, out_ready,
    input  in_ready, out_valid, result, zero, rd_out, illegal_op
  );
endinterface

// File: rtl/alu_exec_stage.sv
// ALU execute stage: decodes the 3-bit ALUControl code, computes on two
// XLEN operands and registers the result behind a valid/ready handshake.
// A one-entry skid buffer (S) behind the output register (R) lets in_ready
// come purely from registered state, so downstream stalls never lose work.
module alu_exec_stage #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_exec_stage_if.slave   bus
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic [4:0]      rd;
    logic            illegal;
  } res_t;

  res_t            r_q, s_q, nxt;
  logic            r_vld, s_vld;
  logic [XLEN-1:0] op_res;
  logic            op_ill;
  logic            accept, drain;

  assign bus.in_ready = !s_vld;
  assign accept       = bus.in_valid && !s_vld;
  assign drain        = r_vld && bus.out_ready;

  // Operation decode and compute; reserved codes produce 0 and flag illegal.
  always_comb begin
    op_res = '0;
    op_ill = 1'b0;
    case (bus.alu_control)
      3'b000:  op_res = bus.src_a + bus.src_b;
      3'b001:  op_res = bus.src_a - bus.src_b;
      3'b010:  op_res = bus.src_a & bus.src_b;
      3'b011:  op_res = bus.src_a | bus.src_b;
      3'b101:  op_res = {{(XLEN-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
      3'b111:  op_res = '0;
      default: op_ill = 1'b1;
    endcase
    nxt = '{result: op_res, zero: (op_res == '0), rd: bus.rd_in, illegal: op_ill};
  end

  // R/S elastic storage; data fields only move on a load so a stalled
  // output stays stable and an emptied R keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      s_vld <= 1'b0;
      r_q   <= '0;
      s_q   <= '0;
    end else if (bus.flush) begin
      r_vld <= 1'b0;
      s_vld <= 1'b0;
    end else if (drain && s_vld) begin
      r_q   <= s_q;
      s_vld <= 1'b0;
    end else if ((drain || !r_vld) && accept) begin
      r_q   <= nxt;
      r_vld <= 1'b1;
    end else if (r_vld && !bus.out_ready && accept) begin
      s_q   <= nxt;
      s_vld <= 1'b1;
    end else if (drain) begin
      r_vld <= 1'b0;
    end
  end

  assign bus.out_valid  = r_vld;
  assign bus.result     = r_q.result;
  assign bus.zero       = r_q.zero;
  assign bus.rd_out     = r_q.rd;
  assign bus.illegal_op = r_q.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a scoreboard queue: expected
// results are pushed on accept and popped on each downstream handshake.
module tb_alu_exec_stage;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic [4:0]      rd;
    logic            illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_stage_if #(.XLEN(XLEN)) ifc ();

  alu_exec_stage #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  exp_t            sb[$];
  int              n_cmp = 0;
  int              n_err = 0;
  logic            prev_stall = 1'b0;
  logic [XLEN-1:0] prev_res;
  logic [4:0]      prev_rd;
  logic            last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU; signed compare done by biasing the sign bit.
  function automatic exp_t model(input logic [2:0] c, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b, input logic [4:0] rd);
    exp_t e;
    logic [XLEN-1:0] bias;
    bias = '0;
    bias[XLEN-1] = 1'b1;
    e.result  = '0;
    e.illegal = 1'b0;
    case (c)
      3'd0: e.result = a + b;
      3'd1: e.result = a - b;
      3'd2: e.result = a & b;
      3'd3: e.result = a | b;
      3'd5: e.result = ((a ^ bias) < (b ^ bias)) ? 1 : 0;
      3'd7: e.result = '0;
      default: e.illegal = 1'b1;
    endcase
    e.zero = (e.result == 0);
    e.rd   = rd;
    return e;
  endfunction

  // One clock: at negedge check output handshake / stability and record
  // the accept, then step past the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (prev_stall && ifc.out_valid) begin
      chk("stall_result_stable", 64'(ifc.result), 64'(prev_res));
      chk("stall_rd_stable", 64'(ifc.rd_out), 64'(prev_rd));
    end
    prev_stall = ifc.out_valid && !ifc.out_ready;
    prev_res   = ifc.result;
    prev_rd    = ifc.rd_out;
    if (ifc.out_valid && ifc.out_ready) begin
      if (sb.size() == 0) chk("unexpected_output", 64'(ifc.rd_out), 64'h0dead);
      else begin
        e = sb.pop_front();
        chk($sformatf("result_rd%0d", e.rd), 64'(ifc.result), 64'(e.result));
        chk($sformatf("zero_rd%0d", e.rd), 64'(ifc.zero), 64'(e.zero));
        chk($sformatf("rd_out_rd%0d", e.rd), 64'(ifc.rd_out), 64'(e.rd));
        chk($sformatf("illegal_rd%0d", e.rd), 64'(ifc.illegal_op), 64'(e.illegal));
      end
    end
    last_acc = ifc.in_valid && ifc.in_ready && !ifc.flush;
    if (ifc.flush) begin
      sb.delete();
      prev_stall = 1'b0;
    end else if (last_acc) begin
      sb.push_back(model(ifc.alu_control, ifc.src_a, ifc.src_b, ifc.rd_in));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] c, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [4:0] rd);
    ifc.in_valid    = 1'b1;
    ifc.alu_control = c;
    ifc.src_a       = a;
    ifc.src_b       = b;
    ifc.rd_in       = rd;
  endtask

  // Offer one op and hold it until accepted (bounded).
  task automatic send(input logic [2:0] c, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input logic [4:0] rd);
    int n;
    set_op(c, a, b, rd);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) chk("accept_timeout", 64'(n), 64'(0));
    ifc.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    ifc.in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    ifc.in_valid = 1'b0; ifc.alu_control = 3'd0; ifc.src_a = '0; ifc.src_b = '0;
    ifc.rd_in = '0; ifc.flush = 1'b0; ifc.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", 64'(ifc.out_valid), 64'(0));
    chk("rst_result", 64'(ifc.result), 64'(0));
    chk("rst_zero", 64'(ifc.zero), 64'(0));
    chk("rst_rd_out", 64'(ifc.rd_out), 64'(0));
    chk("rst_illegal", 64'(ifc.illegal_op), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(ifc.in_ready), 64'(1));
    @(posedge clk); #1;

    // Back-to-back with out_ready=1; out_valid must stay high throughout.
    set_op(3'd0, 5, 7, 5'd10);    cycle();
    chk("b2b_valid1", 64'(ifc.out_valid), 64'(1));
    set_op(3'd1, 5, 5, 5'd11);    cycle();
    chk("b2b_valid2", 64'(ifc.out_valid), 64'(1));
    chk("b2b_sub_zero", 64'(ifc.zero), 64'(1));
    set_op(3'd2, 32'hF0, 32'h3C, 5'd12); cycle();
    chk("b2b_valid3", 64'(ifc.out_valid), 64'(1));
    chk("b2b_and", 64'(ifc.result), 64'h30);
    set_op(3'd3, 32'hF0, 32'h0F, 5'd13); cycle();
    chk("b2b_valid4", 64'(ifc.out_valid), 64'(1));
    chk("b2b_or", 64'(ifc.result), 64'hFF);
    idle(2);
    chk("drained_valid", 64'(ifc.out_valid), 64'(0));

    // Signed slt
    send(3'd5, 32'hFFFF_FFFF, 32'd1, 5'd14);
    chk("slt_neg_lt_pos", 64'(ifc.result), 64'(1));
    send(3'd5, 32'd1, 32'hFFFF_FFFF, 5'd15);
    chk("slt_pos_lt_neg", 64'(ifc.result), 64'(0));
    idle(2);

    // Backpressure: rd1, rd2 accepted; rd3 stalls until R drains.
    ifc.out_ready = 1'b0;
    send(3'd0, 1, 1, 5'd1);
    send(3'd0, 2, 2, 5'd2);
    chk("bp_in_ready_low", 64'(ifc.in_ready), 64'(0));
    set_op(3'd0, 3, 3, 5'd3);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_rd3_stalled", 64'(last_acc), 64'(0));
    end
    chk("bp_hold_rd", 64'(ifc.rd_out), 64'(1));
    chk("bp_hold_result", 64'(ifc.result), 64'(2));
    ifc.out_ready = 1'b1;
    send(3'd0, 3, 3, 5'd3);
    idle(4);
    chk("bp_sb_empty", 64'(sb.size()), 64'(0));

    // Flush with R, S full and a new offer on the same edge.
    ifc.out_ready = 1'b0;
    send(3'd0, 20, 1, 5'd20);
    send(3'd0, 21, 1, 5'd21);
    set_op(3'd0, 22, 1, 5'd22);
    ifc.flush = 1'b1;
    cycle();
    ifc.flush = 1'b0;
    ifc.in_valid = 1'b0;
    chk("flush_out_valid", 64'(ifc.out_valid), 64'(0));
    chk("flush_in_ready", 64'(ifc.in_ready), 64'(1));
    ifc.out_ready = 1'b1;
    idle(4);
    chk("flush_no_output", 64'(ifc.out_valid), 64'(0));

    // Reserved and nop codes
    send(3'd6, 9, 3, 5'd6);
    chk("rsv_out_valid", 64'(ifc.out_valid), 64'(1));
    chk("rsv_illegal", 64'(ifc.illegal_op), 64'(1));
    chk("rsv_result", 64'(ifc.result), 64'(0));
    chk("rsv_zero", 64'(ifc.zero), 64'(1));
    send(3'd7, 9, 3, 5'd7);
    chk("nop_illegal", 64'(ifc.illegal_op), 64'(0));
    chk("nop_result", 64'(ifc.result), 64'(0));
    idle(2);

    // Asynchronous reset with R and S full.
    ifc.out_ready = 1'b0;
    send(3'd0, 40, 2, 5'd8);
    send(3'd0, 41, 2, 5'd9);
    chk("pre_rst_in_ready", 64'(ifc.in_ready), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(ifc.out_valid), 64'(0));
    chk("arst_result", 64'(ifc.result), 64'(0));
    sb.delete();
    prev_stall = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    chk("arst_in_ready", 64'(ifc.in_ready), 64'(1));
    ifc.out_ready = 1'b1;
    idle(3);
    chk("arst_no_output", 64'(ifc.out_valid), 64'(0));
    chk("final_sb_empty", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
